// File: rtl/pwm_capture.sv
// ============================================================================
//  pwm_capture
//  Measures the period and integer duty-cycle percent of an async PWM input.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int TIMEOUT = 65535
) (
    input  logic        SysClk,
    input  logic        Reset,
    input  logic        PWMIn,
    output logic [15:0] Period,
    output logic [7:0]  DutyCycle,
    output logic        Valid,
    output logic        Stuck,
    output logic        Overrun
);

    localparam logic [15:0] c_timeout  = TIMEOUT[15:0];
    localparam logic [4:0]  c_last_itr = 5'd22;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        DIVIDE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic        w_rise;

    logic [15:0] r_pcnt;
    logic [15:0] r_hcnt;
    logic        r_to_fired;
    logic        w_timeout;

    logic [15:0] r_per;
    logic [22:0] r_quo;
    logic [15:0] r_rem;
    logic [4:0]  r_iter;
    logic [22:0] w_dividend;
    logic [16:0] w_rem_sh;
    logic        w_ge;
    logic [15:0] w_diff;
    logic [15:0] w_rem_nxt;
    logic [22:0] w_quo_nxt;
    logic        w_last;

    assign w_rise = r_sync2 & ~r_sync3;

    // Fires once per stuck episode; re-enabled only by a fresh rising edge.
    assign w_timeout = (r_state != DIVIDE) && !w_rise && !r_to_fired
                       && (r_pcnt == c_timeout);

    assign w_dividend = 23'(r_hcnt) * 23'd100;
    assign w_rem_sh   = {r_rem, r_quo[22]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_per});
    // Low 16 bits suffice: when w_ge holds the true difference is below r_per.
    assign w_diff     = w_rem_sh[15:0] - r_per;
    assign w_rem_nxt  = w_ge ? w_diff : w_rem_sh[15:0];
    assign w_quo_nxt  = {r_quo[21:0], w_ge};
    assign w_last     = (r_iter == c_last_itr);

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (w_rise) begin
                    w_state_nxt = DIVIDE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            DIVIDE: begin
                if (w_last) begin
                    w_state_nxt = ARMED;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_pcnt     <= 16'd0;
            r_hcnt     <= 16'd0;
            r_to_fired <= 1'b0;
        end else begin
            r_sync1 <= PWMIn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_rise) begin
                r_pcnt <= 16'd1;
                r_hcnt <= 16'd1;
            end else begin
                if (r_pcnt != 16'hFFFF) begin
                    r_pcnt <= r_pcnt + 16'd1;
                end
                if (r_sync2 && (r_hcnt != 16'hFFFF)) begin
                    r_hcnt <= r_hcnt + 16'd1;
                end
            end
            if (w_rise) begin
                r_to_fired <= 1'b0;
            end else if (w_timeout) begin
                r_to_fired <= 1'b1;
            end
        end
    end

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_per  <= 16'd0;
            r_quo  <= 23'd0;
            r_rem  <= 16'd0;
            r_iter <= 5'd0;
        end else if ((r_state == ARMED) && w_rise) begin
            r_per  <= r_pcnt;
            r_quo  <= w_dividend;
            r_rem  <= 16'd0;
            r_iter <= 5'd0;
        end else if (r_state == DIVIDE) begin
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
            r_iter <= r_iter + 5'd1;
        end
    end

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            Period    <= 16'd0;
            DutyCycle <= 8'd0;
            Valid     <= 1'b0;
            Stuck     <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            Valid   <= 1'b0;
            Overrun <= 1'b0;
            if ((r_state == DIVIDE) && w_last) begin
                Period    <= r_per;
                DutyCycle <= w_quo_nxt[7:0];
                Valid     <= 1'b1;
                Stuck     <= 1'b0;
            end else if (w_timeout) begin
                Period    <= 16'd0;
                DutyCycle <= r_sync2 ? 8'd100 : 8'd0;
                Valid     <= 1'b1;
                Stuck     <= 1'b1;
            end
            if ((r_state == DIVIDE) && w_rise) begin
                Overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  tb_pwm_capture
//  Directed vector bench for pwm_capture.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    logic        SysClk = 1'b0;
    logic        Reset  = 1'b0;
    logic        PWMIn  = 1'b0;
    logic [15:0] Period,    Period_to;
    logic [7:0]  DutyCycle, DutyCycle_to;
    logic        Valid,     Valid_to;
    logic        Stuck,     Stuck_to;
    logic        Overrun,   Overrun_to;

    pwm_capture u_dut (
        .SysClk(SysClk), .Reset(Reset), .PWMIn(PWMIn),
        .Period(Period), .DutyCycle(DutyCycle), .Valid(Valid),
        .Stuck(Stuck), .Overrun(Overrun)
    );

    pwm_capture #(.TIMEOUT(100)) u_dut_to (
        .SysClk(SysClk), .Reset(Reset), .PWMIn(PWMIn),
        .Period(Period_to), .DutyCycle(DutyCycle_to), .Valid(Valid_to),
        .Stuck(Stuck_to), .Overrun(Overrun_to)
    );

    always #5 SysClk = ~SysClk;

    typedef struct {
        int high;
        int low;
        int nper;
        int exp_p;
        int exp_d;
        int exp_nv;
        int exp_no;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int nvalid;
    int novr;
    int exp_p, exp_d, exp_s;
    bit sel;
    int a_p, a_d, a_v, a_s, a_o;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, sample the selected DUT and check any Valid.
    task automatic step();
        @(negedge SysClk);
        a_p = sel ? int'(Period_to)    : int'(Period);
        a_d = sel ? int'(DutyCycle_to) : int'(DutyCycle);
        a_v = sel ? int'(Valid_to)     : int'(Valid);
        a_s = sel ? int'(Stuck_to)     : int'(Stuck);
        a_o = sel ? int'(Overrun_to)   : int'(Overrun);
        if (a_v == 1) begin
            nvalid++;
            chk("valid_period", a_p, exp_p);
            chk("valid_duty",   a_d, exp_d);
            chk("valid_stuck",  a_s, exp_s);
        end
        if (a_o == 1) novr++;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        PWMIn = 1'b0;
        repeat (3) step();
        Reset  = 1'b1;
        nvalid = 0;
        novr   = 0;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            PWMIn = 1'b1;
            repeat (hi) step();
            PWMIn = 1'b0;
            repeat (lo) step();
        end
    endtask

    initial begin
        vecs[0] = '{3,  4,   16, 7,    42, 4, 11};
        vecs[1] = '{25, 25,  4,  50,   50, 3, 0};
        vecs[2] = '{1,  29,  5,  30,   3,  4, 0};
        vecs[3] = '{29, 1,   5,  30,   96, 4, 0};
        vecs[4] = '{5,  5,   12, 10,   50, 4, 7};
        vecs[5] = '{1,  999, 3,  1000, 0,  2, 0};
        vecs[6] = '{33, 67,  3,  100,  33, 2, 0};
        sel = 1'b0;
        exp_p = 0; exp_d = 0; exp_s = 0;
        nvalid = 0; novr = 0;

        // Reset with a toggling input: all outputs zero.
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PWMIn = ~PWMIn;
            step();
        end
        chk("rst_period",  a_p, 0);
        chk("rst_duty",    a_d, 0);
        chk("rst_valid",   a_v, 0);
        chk("rst_stuck",   a_s, 0);
        chk("rst_overrun", a_o, 0);

        // Generator loopback 500/20%; first result 24 cycles after second rise.
        PWMIn = 1'b0;
        Reset = 1'b1;
        nvalid = 0; novr = 0;
        exp_p = 500; exp_d = 20; exp_s = 0;
        wave(100, 400, 1);
        chk("loop_no_valid_first_rise", nvalid, 0);
        PWMIn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 25) chk("loop_no_early_valid", nvalid, 0);
            if (k == 26) chk("loop_latency_valid", a_v, 1);
        end
        repeat (74) step();
        PWMIn = 1'b0;
        repeat (400) step();
        wave(100, 400, 2);
        repeat (40) step();
        chk("loop_nvalid", nvalid, 3);
        chk("loop_novr",   novr,   0);

        // Steady waveforms from the vector table.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            exp_p = vecs[v].exp_p;
            exp_d = vecs[v].exp_d;
            exp_s = 0;
            wave(vecs[v].high, vecs[v].low, vecs[v].nper);
            PWMIn = 1'b0;
            repeat (40) step();
            chk($sformatf("vec%0d_nvalid", v),  nvalid, vecs[v].exp_nv);
            chk($sformatf("vec%0d_overrun", v), novr,   vecs[v].exp_no);
        end

        // Stuck high / recovery / stuck low on the TIMEOUT=100 instance.
        sel = 1'b1;
        do_reset();
        exp_p = 0; exp_d = 100; exp_s = 1;
        PWMIn = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            step();
            if (k == 102) chk("stuck_no_early_valid", nvalid, 0);
            if (k == 103) chk("stuck_timeout_valid", a_v, 1);
        end
        repeat (200) step();
        chk("stuck_fires_once", nvalid, 1);
        chk("stuck_level", a_s, 1);
        PWMIn = 1'b0;
        repeat (25) step();
        nvalid = 0;
        exp_p = 50; exp_d = 50; exp_s = 0;
        wave(25, 25, 1);
        chk("stuck_held_one_rise", a_s, 1);
        wave(25, 25, 2);
        chk("recover_nvalid", nvalid, 2);
        chk("recover_stuck", a_s, 0);
        exp_p = 0; exp_d = 0; exp_s = 1;
        repeat (150) step();
        chk("stuck_low_nvalid", nvalid, 3);
        chk("stuck_low_level", a_s, 1);

        // Reset in the middle of a division.
        sel = 1'b0;
        do_reset();
        exp_p = 50; exp_d = 50; exp_s = 0;
        wave(25, 25, 3);
        chk("mid_pre_nvalid", nvalid, 2);
        PWMIn = 1'b1;
        repeat (12) step();
        Reset = 1'b0;
        repeat (2) step();
        chk("mid_rst_period",  a_p, 0);
        chk("mid_rst_duty",    a_d, 0);
        chk("mid_rst_valid",   a_v, 0);
        chk("mid_rst_stuck",   a_s, 0);
        chk("mid_rst_overrun", a_o, 0);
        repeat (2) step();
        PWMIn = 1'b0;
        Reset = 1'b1;
        nvalid = 0;
        repeat (40) step();
        chk("mid_discarded", nvalid, 0);
        wave(25, 25, 1);
        chk("mid_one_rise_no_valid", nvalid, 0);
        PWMIn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 26) chk("mid_rearm_valid", a_v, 1);
        end
        chk("mid_rearm_nvalid", nvalid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
